// File: rtl/uart_tx_fifo_ctrl_if.sv
// Bus-side bundle of the UART TX FIFO: write port, read/pop port, status and error flags.
// Master drives requests and data; the FIFO connects through the slave modport.
interface uart_tx_fifo_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
);
   localparam int PTR_W = $clog2(DEPTH);

   logic                  flush;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [PTR_W:0]        count;
   logic                  overflow;
   logic                  underflow;
   logic                  clr_err;

   modport master (
      output flush, wr_en, wr_data, rd_en, clr_err,
      input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  flush, wr_en, wr_data, rd_en, clr_err,
      output rd_data, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/uart_tx_fifo_ctrl.sv
// Synchronous TX byte FIFO between the register write side and the UART serialiser.
// Standard (registered) or first-word-fall-through read, with thresholds, count and sticky errors.
module uart_tx_fifo_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int PTR_W      = $clog2(DEPTH),
   parameter int FWFT       = 0,
   parameter int AFULL_THR  = DEPTH - 2,
   parameter int AEMPTY_THR = 2
)(
   input logic                clk,
   input logic                rstn,
   uart_tx_fifo_ctrl_if.slave bus
);

   localparam logic [PTR_W:0] AF_LVL = AFULL_THR[PTR_W:0];
   localparam logic [PTR_W:0] AE_LVL = AEMPTY_THR[PTR_W:0];

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W:0]        r_wr_ptr;
   logic [PTR_W:0]        r_rd_ptr;
   logic [PTR_W:0]        r_count;
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic                  w_wr_rej;
   logic                  w_rd_rej;
   logic [PTR_W-1:0]      w_wr_addr;
   logic [PTR_W-1:0]      w_rd_addr;

   // Extra pointer MSB distinguishes full from empty when the low bits match.
   always_comb begin
      w_wr_addr = r_wr_ptr[PTR_W-1:0];
      w_rd_addr = r_rd_ptr[PTR_W-1:0];
      w_empty   = (r_wr_ptr == r_rd_ptr);
      w_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) && (w_wr_addr == w_rd_addr);
      w_wr_acc  = bus.wr_en && !w_full  && !bus.flush;
      w_rd_acc  = bus.rd_en && !w_empty && !bus.flush;
      w_wr_rej  = bus.wr_en &&  w_full  && !bus.flush;
      w_rd_rej  = bus.rd_en &&  w_empty && !bus.flush;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (bus.flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_wr_acc && !w_rd_acc)      r_count <= r_count + 1'b1;
         else if (w_rd_acc && !w_wr_acc) r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_acc) r_mem[w_wr_addr] <= bus.wr_data;
   end

   // A new error event takes precedence over a clear in the same cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_rej)         r_overflow <= 1'b1;
         else if (bus.clr_err) r_overflow <= 1'b0;
         if (w_rd_rej)         r_underflow <= 1'b1;
         else if (bus.clr_err) r_underflow <= 1'b0;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign bus.rd_data  = r_mem[w_rd_addr];
         assign bus.rd_valid = !w_empty;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] r_rd_data;
         logic                  r_rd_valid;

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               r_rd_data  <= '0;
               r_rd_valid <= 1'b0;
            end else begin
               r_rd_valid <= w_rd_acc;
               if (w_rd_acc) r_rd_data <= r_mem[w_rd_addr];
            end
         end

         assign bus.rd_data  = r_rd_data;
         assign bus.rd_valid = r_rd_valid;
      end
   endgenerate

   assign bus.full         = w_full;
   assign bus.empty        = w_empty;
   assign bus.count        = r_count;
   assign bus.almost_full  = (r_count >= AF_LVL);
   assign bus.almost_empty = (r_count <= AE_LVL);
   assign bus.overflow     = r_overflow;
   assign bus.underflow    = r_underflow;

endmodule
